// File: rtl/div_freq_prog.sv
// Runtime-programmable frequency divider: 50%-duty square wave plus a one-cycle
// tick on each rising edge of the output. The half-period can be reloaded at
// runtime; the new value is taken only at the rising boundary so no runt pulse
// is ever produced.
module div_freq_prog #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned DEFAULT_HZ = 1000,
  parameter int unsigned WIDTH      = 26
) (
  input  logic             clkFPGA,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             upd_pend,
  output logic             load_err
);

  localparam longint unsigned DEF_HALF =
      longint'(CLK_HZ) / (64'd2 * longint'(DEFAULT_HZ));

  // The reset half-period must be non-zero and fit the counter.
  if (DEF_HALF == 64'd0 || DEF_HALF >= (64'd1 << WIDTH)) begin : g_bad_def_half
    $fatal(1, "div_freq_prog: DEF_HALF out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] DefHalf = WIDTH'(DEF_HALF);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             upd_q, upd_d;
  logic             err_q, err_d;
  logic             last_cnt;
  logic             boundary;

  // Next-state: half-period counting, boundary-aligned reload, load capture.
  always_comb begin
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    active_d = active_q;
    pend_d   = pend_q;
    upd_d    = upd_q;
    err_d    = 1'b0;

    last_cnt = (cnt_q == active_q - WIDTH'(1));
    // Rising boundary: the only point where the half-period may change.
    boundary = en && !clk_q && last_cnt;
    tick_d   = boundary;

    if (en) begin
      if (last_cnt) begin
        cnt_d = '0;
        clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end

    if (boundary && upd_q) begin
      active_d = pend_q;
      upd_d    = 1'b0;
    end

    // A load in the boundary cycle lands after the old pending value is applied.
    if (div_load) begin
      if (div_value != '0) begin
        pend_d = div_value;
        upd_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and registered outputs, asynchronously reset to the default rate.
  always_ff @(posedge clkFPGA or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      active_q <= DefHalf;
      pend_q   <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign clk_out    = clk_q;
  assign tick       = tick_q;
  assign div_active = active_q;
  assign upd_pend   = upd_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_div_freq_prog.sv
// Bench for div_freq_prog: directed scenarios followed by random enable/load
// traffic. A timeline model predicts each edge's outputs into a queue that an
// independent monitor drains and compares.
module tb_div_freq_prog;

  localparam int unsigned CLK_HZ     = 1000;
  localparam int unsigned DEFAULT_HZ = 100;
  localparam int unsigned WIDTH      = 8;
  localparam int          DEF_HALF   = CLK_HZ / (2 * DEFAULT_HZ);

  logic             clkFPGA = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             div_load = 1'b0;
  logic [WIDTH-1:0] div_value = '0;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_active;
  logic             upd_pend;
  logic             load_err;

  div_freq_prog #(
    .CLK_HZ    (CLK_HZ),
    .DEFAULT_HZ(DEFAULT_HZ),
    .WIDTH     (WIDTH)
  ) dut (
    .clkFPGA   (clkFPGA),
    .rst       (rst),
    .en        (en),
    .div_load  (div_load),
    .div_value (div_value),
    .clk_out   (clk_out),
    .tick      (tick),
    .div_active(div_active),
    .upd_pend  (upd_pend),
    .load_err  (load_err)
  );

  always #5 clkFPGA = ~clkFPGA;

  typedef struct {
    logic clk_out;
    logic tick;
    int   div_active;
    logic upd_pend;
    logic load_err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Timeline model: counts enabled edges and schedules the next toggle at an
  // absolute enabled-edge index.
  int m_ecnt, m_next, m_active, m_pend;
  bit m_level, m_upd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task model_reset();
    m_ecnt   = 0;
    m_next   = DEF_HALF;
    m_active = DEF_HALF;
    m_pend   = 0;
    m_level  = 1'b0;
    m_upd    = 1'b0;
  endtask

  task model_step();
    exp_t e;
    bit   rising;
    bit   err;
    rising = 1'b0;
    err    = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (en) begin
        m_ecnt++;
        if (m_ecnt == m_next) begin
          m_level = !m_level;
          if (m_level) begin
            rising = 1'b1;
            if (m_upd) begin
              m_active = m_pend;
              m_upd    = 1'b0;
            end
          end
          m_next = m_ecnt + m_active;
        end
      end
      if (div_load) begin
        if (div_value != '0) begin
          m_pend = int'(div_value);
          m_upd  = 1'b1;
        end else begin
          err = 1'b1;
        end
      end
    end
    e.clk_out    = m_level;
    e.tick       = rising;
    e.div_active = m_active;
    e.upd_pend   = m_upd;
    e.load_err   = err;
    sb.push_back(e);
  endtask

  // Apply one cycle of inputs and record the predicted result of the next edge.
  task automatic drive(input logic r, input logic e, input logic l, input logic [WIDTH-1:0] v);
    @(negedge clkFPGA);
    rst       = r;
    en        = e;
    div_load  = l;
    div_value = v;
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, '0);
  endtask

  function automatic bit ready(input int kind);
    case (kind)
      0:       return m_level;
      1:       return !m_level;
      2:       return !m_level && (m_ecnt + 1 == m_next) && !m_upd;
      default: return !m_level && (m_next - m_ecnt >= 3);
    endcase
  endfunction

  // Idle with en=1 until the model reaches the requested phase, bounded.
  task automatic wait_phase(input int kind, input string name);
    for (int i = 0; i < 1200; i++) begin
      if (ready(kind)) break;
      run(1);
    end
    if (!ready(kind)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: phase not reached within budget", name);
    end
  endtask

  // Monitor: every edge the DUT presents a full output set; compare it with the
  // oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clkFPGA);
      cyc++;
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("clk_out", 32'(clk_out), 32'(e.clk_out));
        check("tick", 32'(tick), 32'(e.tick));
        check("div_active", 32'(div_active), e.div_active);
        check("upd_pend", 32'(upd_pend), 32'(e.upd_pend));
        check("load_err", 32'(load_err), 32'(e.load_err));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, '0);
    // Default rate: first rise on edge 5 after release, 5/5 duty.
    drive(1'b0, 1'b1, 1'b0, '0);
    run(30);

    // Reload to 3 during a high phase.
    wait_phase(0, "reload_high");
    drive(1'b0, 1'b1, 1'b1, WIDTH'(3));
    run(30);

    // Zero load is rejected; then 7 and 2 before the boundary, 2 wins.
    drive(1'b0, 1'b1, 1'b1, '0);
    run(3);
    wait_phase(0, "last_wins_high");
    drive(1'b0, 1'b1, 1'b1, WIDTH'(7));
    drive(1'b0, 1'b1, 1'b1, WIDTH'(2));
    run(20);

    // Freeze mid-low-phase for 8 cycles.
    wait_phase(1, "enable_low");
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, '0);
    run(20);

    // Load 1 exactly on a boundary with nothing pending.
    wait_phase(2, "collision");
    drive(1'b0, 1'b1, 1'b1, WIDTH'(1));
    run(20);

    // Largest half-period.
    drive(1'b0, 1'b1, 1'b1, WIDTH'(255));
    run(1100);

    // Random enable and load traffic, including zero loads.
    for (int i = 0; i < 2000; i++) begin
      drive(1'b0, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0),
            WIDTH'($urandom_range(0, 12)));
    end

    // Async reset mid-period while an update is pending.
    drive(1'b0, 1'b1, 1'b1, WIDTH'(4));
    run(30);
    wait_phase(3, "reset_setup");
    drive(1'b0, 1'b1, 1'b1, WIDTH'(9));
    run(1);
    @(posedge clkFPGA);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 32'd0);
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_div_active", 32'(div_active), DEF_HALF);
    check("async_rst_upd_pend", 32'(upd_pend), 32'd0);
    check("async_rst_load_err", 32'(load_err), 32'd0);
    drive(1'b1, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    run(30);

    @(posedge clkFPGA);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_freq_prog.md
Name: div_freq_prog

Overview:
- Runtime-programmable frequency divider. Generates a 50%-duty square wave and a one-cycle tick from the board clock.
- Generalised successor to the fixed 1 kHz divider: parametrised clock rate, default output rate and counter width.
- Supports glitch-free divisor reload at period boundaries, an enable, and error reporting.
- Feeds the display multiplexer and BCD counter time base. The tick is the preferred synchronous enable; clk_out is for visible/external use.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- DEFAULT_HZ, 1000, output frequency after reset.
- WIDTH, 26, width of the half-period count and divisor registers.
- Derived constant DEF_HALF = CLK_HZ/(2*DEFAULT_HZ), integer division. Requirements: DEF_HALF >= 1 and DEF_HALF < 2**WIDTH. Elaboration check; violation is a fatal error.

Ports:
- clkFPGA  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; 0 freezes the divider.
- div_load  in  1  one-cycle strobe requesting a new half-period value.
- div_value  in  WIDTH  requested half-period N, in clkFPGA cycles. Output period = 2N cycles.
- clk_out  out  1  divided square wave, registered.
- tick  out  1  one-cycle pulse, asserted in the cycle clk_out becomes 1.
- div_active  out  WIDTH  half-period value currently in use.
- upd_pend  out  1  a loaded value is waiting for the next period boundary.
- load_err  out  1  one-cycle pulse: div_load seen with div_value==0.

Behaviour:
- Reset (async assert, sync release): cnt=0, clk_out=0, tick=0, div_active=DEF_HALF, pending=0, upd_pend=0, load_err=0.
- Counting, when en=1:
  - if cnt==div_active-1: cnt<=0 and clk_out<=~clk_out;
  - else cnt<=cnt+1.
- tick=1 only in the cycle where clk_out transitions 0->1; otherwise tick=0. tick never exceeds one cycle.
- First rising edge of clk_out (with tick) occurs on the div_active-th clkFPGA edge after reset release, given en=1 throughout.
- Period boundary: the cycle where cnt==div_active-1, clk_out==0 and en==1, i.e. the 0->1 toggle.
  - If upd_pend==1 at a boundary: div_active<=pending and upd_pend<=0. The new value governs the following high half onward.
  - Changing div_active only at this point keeps duty exactly 50% and guarantees no runt pulse.
- Load handling:
  - div_load=1 with div_value!=0: pending<=div_value, upd_pend<=1. Last load wins; a later load before the boundary overwrites pending.
  - div_load=1 with div_value==0: rejected; pending and upd_pend unchanged; load_err=1 for that cycle.
- Load coinciding with a boundary: the boundary applies the old pending contents (if upd_pend was 1). The new value is then pending, upd_pend=1, applied at the next boundary. If upd_pend was 0, div_active is unchanged and the new value pends.
- en=0: cnt, clk_out and div_active hold; tick=0. Loads are still accepted into pending. Boundaries cannot occur while disabled.
- en 0->1: counting resumes from the held cnt. No extra or missing tick.
- Reset mid-period: immediate return to reset values; a pending update is discarded.
- Arithmetic: cnt is WIDTH bits and compared against div_active-1; div_active>=1 always holds.
  - N=1 gives clk_out toggling every cycle (period 2) and tick every 2 cycles.
  - Maximum N=2**WIDTH-1 without overflow.

Test Plan:
- Reset/default: CLK_HZ=1000, DEFAULT_HZ=100 (DEF_HALF=5), en=1 -> clk_out rises on edge 5 after reset release with tick=1. High for 5 cycles, low for 5; tick every 10 cycles; div_active=5.
- Reload: load div_value=3 mid-high-phase -> upd_pend=1; current period completes at 5/5. From the next rising boundary, period is 6 cycles (3/3), upd_pend=0, div_active=3.
- Error/last-wins: load 0 -> load_err pulse, upd_pend stays 0. Load 7 then 2 before the boundary -> only 2 is applied; period becomes 4.
- Enable: deassert en for 8 cycles mid-low-phase -> clk_out, cnt and tick frozen (tick=0). On re-enable, the remaining low-phase cycles complete with no lost or extra tick.
- Boundary collision and N=1: load 1 on the exact boundary cycle while upd_pend=0 -> applied at the following boundary. Then clk_out toggles every cycle and tick fires every 2 cycles.
- Async reset mid-period with upd_pend=1 -> all outputs return to reset values immediately, without waiting for a clock edge. Pending is discarded; div_active=5.
